path_metric_unit: RTL and testbench

PATH_METRIC_UNIT -- requirements
Module: path_metric_unit

---
 rtl/path_metric_unit_if.sv | 29 ++
 rtl/path_metric_unit.sv | 164 ++++++++++++++++
 tb/tb_path_metric_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/path_metric_unit_if.sv
// Stage handshake and result bus for path_metric_unit.
// No latency: wires only. The producer and consumer are on opposite modports.
interface path_metric_unit_if #(
  parameter int K    = 7,
  parameter int PM_W = 7,
  parameter int BM_W = 2
);
  localparam int S = 1 << (K - 1);

  logic                clear;
  logic [4*BM_W-1:0]   metrics;
  logic                in_valid;
  logic                in_ready;
  logic [S-1:0]        decisions;
  logic                out_valid;
  logic                out_ready;
  logic [S*PM_W-1:0]   costs;
  logic [K-2:0]        best_state;

  modport master (
    output clear, metrics, in_valid, out_ready,
    input  in_ready, decisions, out_valid, costs, best_state
  );

  modport slave (
    input  clear, metrics, in_valid, out_ready,
    output in_ready, decisions, out_valid, costs, best_state
  );
endinterface

// File: rtl/path_metric_unit.sv
// Viterbi add-compare-select over one trellis stage; PMU_NORM_EN adds a min-subtract NORM cycle.
// Latency: out_valid N+1 edges after accept (N+2 with PMU_NORM_EN), N = S/ACS_PAR.
// Backpressure: results hold in DONE until out_ready; in_ready is high only in IDLE.
module path_metric_unit #(
  parameter int           K       = 7,
  parameter int           PM_W    = 7,
  parameter int           BM_W    = 2,
  parameter int           ACS_PAR = 64,
  parameter logic [K-1:0] G0      = 7'o133,
  parameter logic [K-1:0] G1      = 7'o171
) (
  input  logic              clk,
  input  logic              reset_n,
  path_metric_unit_if.slave bus
);
  localparam int S  = 1 << (K - 1);
  localparam int N  = S / ACS_PAR;
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = K - 1;
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_HALF = {1'b1, {(PM_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, NORM, DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     step_q;
  logic [4*BM_W-1:0] bm_q;
  logic [PM_W-1:0]   pm_q [2][S];
  logic              sel_q;
  logic [S-1:0]      dec_q;
  logic [K-2:0]      best_q;
  logic [PM_W-1:0]   min_q;
  logic [K-2:0]      min_idx_q;
  logic              out_valid_q;

  logic              last_step;
  logic [PM_W-1:0]   acs_pm  [ACS_PAR];
  logic [K-2:0]      acs_j   [ACS_PAR];
  logic [ACS_PAR-1:0] acs_dec;
  logic [PM_W-1:0]   step_min;
  logic [K-2:0]      step_idx;

  assign last_step = (step_q == TW'(N - 1));

  // One slice of ACS_PAR next-states; predecessors are read from the live bank.
  always_comb begin
    logic [K-2:0]  j;
    logic [K-1:0]  r0, r1;
    logic [1:0]    sym0, sym1;
    logic [K-2:0]  p0, p1;
    logic [PM_W:0] cand0, cand1, win;
    step_min = (step_q == '0) ? PM_MAX : min_q;
    step_idx = (step_q == '0) ? '0 : min_idx_q;
    acs_dec  = '0;
    for (int i = 0; i < ACS_PAR; i++) begin
      j     = SW'(int'(step_q) * ACS_PAR + i);
      r0    = {1'b0, j};
      r1    = {1'b1, j};
      sym0  = {^(r0 & G0), ^(r0 & G1)};
      sym1  = {^(r1 & G0), ^(r1 & G1)};
      p0    = {1'b0, j[K-2:1]};
      p1    = {1'b1, j[K-2:1]};
      cand0 = {1'b0, pm_q[sel_q][p0]} + (PM_W+1)'(bm_q[sym0*BM_W +: BM_W]);
      cand1 = {1'b0, pm_q[sel_q][p1]} + (PM_W+1)'(bm_q[sym1*BM_W +: BM_W]);
      acs_dec[i] = (cand1 < cand0);
      win        = acs_dec[i] ? cand1 : cand0;
`ifdef PMU_NORM_EN
      acs_pm[i]  = win[PM_W-1:0];
`else
      acs_pm[i]  = win[PM_W] ? PM_MAX : win[PM_W-1:0];
`endif
      acs_j[i]   = j;
      // Strict compare in ascending index order keeps the lowest index on ties.
      if (acs_pm[i] < step_min) begin
        step_min = acs_pm[i];
        step_idx = j;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!bus.clear && bus.in_valid) state_d = RUN;
      RUN: begin
        if (last_step) begin
`ifdef PMU_NORM_EN
          state_d = NORM;
`else
          state_d = DONE;
`endif
        end
      end
      NORM:    state_d = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      bm_q        <= '0;
      sel_q       <= 1'b0;
      dec_q       <= '0;
      best_q      <= '0;
      min_q       <= '0;
      min_idx_q   <= '0;
      out_valid_q <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < S; s++)
          pm_q[b][s] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.clear) begin
            for (int s = 0; s < S; s++)
              pm_q[sel_q][s] <= (s == 0) ? '0 : PM_HALF;
          end else if (bus.in_valid) begin
            bm_q   <= bus.metrics;
            step_q <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < ACS_PAR; i++) begin
            pm_q[~sel_q][acs_j[i]] <= acs_pm[i];
            dec_q[acs_j[i]]        <= acs_dec[i];
          end
          min_q     <= step_min;
          min_idx_q <= step_idx;
          step_q    <= last_step ? '0 : step_q + 1'b1;
          if (last_step) begin
            sel_q  <= ~sel_q;
            best_q <= step_idx;
          end
        end
        NORM: begin
          for (int s = 0; s < S; s++)
            pm_q[sel_q][s] <= pm_q[sel_q][s] - min_q;
        end
        DONE: begin
          if (!out_valid_q)
            out_valid_q <= 1'b1;
          else if (bus.out_ready)
            out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.decisions  = dec_q;
  assign bus.best_state = best_q;

  always_comb begin
    bus.costs = '0;
    for (int s = 0; s < S; s++)
      bus.costs[s*PM_W +: PM_W] = pm_q[sel_q][s];
  end
endmodule

// File: tb/tb_path_metric_unit.sv
// Directed bench: runs ACS_PAR=64 and ACS_PAR=16 instances side by side against a stage model.
module tb_path_metric_unit;
  localparam int K    = 7;
  localparam int S    = 64;
  localparam int PM_W = 7;
  localparam int BM_W = 2;
`ifdef PMU_NORM_EN
  localparam int LAT64 = 3;
  localparam int LAT16 = 6;
`else
  localparam int LAT64 = 2;
  localparam int LAT16 = 5;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  path_metric_unit_if #(.K(K), .PM_W(PM_W), .BM_W(BM_W)) bus64 ();
  path_metric_unit_if #(.K(K), .PM_W(PM_W), .BM_W(BM_W)) bus16 ();

  path_metric_unit #(.K(K), .PM_W(PM_W), .BM_W(BM_W), .ACS_PAR(64)) u_pmu64 (
    .clk(clk), .reset_n(reset_n), .bus(bus64));
  path_metric_unit #(.K(K), .PM_W(PM_W), .BM_W(BM_W), .ACS_PAR(16)) u_pmu16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16));

  int checks = 0;
  int errors = 0;

  int           pm_m [S];
  logic [S-1:0] dec_m;
  int           best_m;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [S*PM_W-1:0] model_costs();
    logic [S*PM_W-1:0] v;
    v = '0;
    for (int j = 0; j < S; j++) v[j*PM_W +: PM_W] = 7'(pm_m[j]);
    return v;
  endfunction

  task automatic model_stage(input logic [7:0] bm);
    int         nw [S];
    int         c [2];
    int         mn;
    logic [6:0] r;
    logic [1:0] sym;
    int         p;
    mn = 1 << 30;
    best_m = 0;
    for (int j = 0; j < S; j++) begin
      for (int x = 0; x < 2; x++) begin
        r    = 7'((x << 6) | j);
        sym  = {^(r & 7'o133), ^(r & 7'o171)};
        p    = (x << 5) | (j >> 1);
        c[x] = pm_m[p] + int'(bm[sym*2 +: 2]);
      end
      dec_m[j] = (c[1] < c[0]);
      nw[j] = dec_m[j] ? c[1] : c[0];
`ifndef PMU_NORM_EN
      if (nw[j] > 127) nw[j] = 127;
`endif
      if (nw[j] < mn) begin
        mn = nw[j];
        best_m = j;
      end
    end
    for (int j = 0; j < S; j++) begin
`ifdef PMU_NORM_EN
      pm_m[j] = (nw[j] - mn) & 127;
`else
      pm_m[j] = nw[j];
`endif
    end
  endtask

  task automatic drive_both(input logic vld, input logic clr, input logic [7:0] bm);
    bus64.in_valid = vld; bus16.in_valid = vld;
    bus64.clear    = clr; bus16.clear    = clr;
    bus64.metrics  = bm;  bus16.metrics  = bm;
  endtask

  // Drives one stage into both units and checks latency, hold and results.
  task automatic stage(input logic [7:0] bm, input int hold, input bit mid_clear);
    int l64, l16;
    drive_both(1'b1, 1'b0, bm);
    @(posedge clk); #1;
    drive_both(1'b0, mid_clear, bm);
    model_stage(bm);
    l64 = -1;
    l16 = -1;
    for (int e = 1; e <= 12 && (l64 < 0 || l16 < 0); e++) begin
      @(posedge clk); #1;
      bus64.clear = 1'b0; bus16.clear = 1'b0;
      if (l64 < 0 && bus64.out_valid) l64 = e;
      if (l16 < 0 && bus16.out_valid) l16 = e;
    end
    check("lat64", l64, LAT64);
    check("lat16", l16, LAT16);
    for (int h = 0; h < hold; h++) begin
      check("hold_flags", {bus16.out_valid, bus16.in_ready, bus64.out_valid, bus64.in_ready}, 4'b1010);
      check("hold_costs64", bus64.costs, model_costs());
      check("hold_dec16", bus16.decisions, dec_m);
      @(posedge clk); #1;
    end
    check("costs64", bus64.costs, model_costs());
    check("costs16", bus16.costs, model_costs());
    check("dec64", bus64.decisions, dec_m);
    check("dec16", bus16.decisions, dec_m);
    check("best64", bus64.best_state, best_m);
    check("best16", bus16.best_state, best_m);
    bus64.out_ready = 1'b1; bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus64.out_ready = 1'b0; bus16.out_ready = 1'b0;
    check("release", {bus64.in_ready, bus16.in_ready, bus64.out_valid, bus16.out_valid}, 4'b1100);
  endtask

  task automatic do_clear(input logic with_valid);
    logic [S*PM_W-1:0] exp_v;
    drive_both(with_valid, 1'b1, 8'h55);
    @(posedge clk); #1;
    drive_both(1'b0, 1'b0, 8'h00);
    exp_v = '0;
    for (int j = 0; j < S; j++) begin
      pm_m[j] = (j == 0) ? 0 : 64;
      exp_v[j*PM_W +: PM_W] = (j == 0) ? 7'd0 : 7'd64;
    end
    for (int c = 0; c < 3; c++) begin
      check("clr_idle", {bus64.in_ready, bus16.in_ready, bus64.out_valid, bus16.out_valid}, 4'b1100);
      @(posedge clk); #1;
    end
    check("clr_costs64", bus64.costs, exp_v);
    check("clr_costs16", bus16.costs, exp_v);
  endtask

  initial begin
    logic [S*PM_W-1:0] all_sat;
    drive_both(1'b0, 1'b0, 8'h00);
    bus64.out_ready = 1'b0; bus16.out_ready = 1'b0;
    for (int j = 0; j < S; j++) pm_m[j] = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_costs64", bus64.costs, '0);
    check("rst_costs16", bus16.costs, '0);
    check("rst_dec", {bus64.decisions, bus16.decisions}, '0);
    check("rst_best", {bus64.best_state, bus16.best_state}, '0);
    check("rst_flags", {bus64.in_ready, bus16.in_ready, bus64.out_valid, bus16.out_valid}, 4'b1100);

    // All-zero metrics from reset: everything stays zero.
    stage(8'h00, 0, 1'b0);
    check("zero_costs", bus64.costs, '0);
    check("zero_dec", bus64.decisions, '0);
    check("zero_best", bus16.best_state, 0);

    // Clear wins over a simultaneous in_valid.
    do_clear(1'b1);

    // Only symbol 00 is free: the all-zero path keeps metric 0.
    for (int n = 0; n < 10; n++) begin
      stage(8'hFC, 0, 1'b0);
      check("free_pm0", bus64.costs[6:0], 7'd0);
      check("free_best", bus64.best_state, 6'd0);
      check("free_dec0", bus64.decisions[0], 1'b0);
    end

    // Every branch costs 3.
    all_sat = '1;
    for (int n = 0; n < 60; n++) begin
      stage(8'hFF, 0, 1'b0);
`ifdef PMU_NORM_EN
      check("norm_min", bus64.costs[bus64.best_state*PM_W +: PM_W], 7'd0);
`endif
    end
`ifndef PMU_NORM_EN
    check("sat_all64", bus64.costs, all_sat);
    check("sat_all16", bus16.costs, all_sat);
`endif

    // Held results under backpressure, then clear outside IDLE ignored.
    do_clear(1'b0);
    stage(8'h1B, 10, 1'b0);
    stage(8'hE4, 0, 1'b1);

    for (int n = 0; n < 200; n++) stage(8'($urandom), 0, 1'b0);

    // Reset in the middle of a stage.
    drive_both(1'b1, 1'b0, 8'h9C);
    @(posedge clk); #1;
    drive_both(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int j = 0; j < S; j++) pm_m[j] = 0;
    for (int c = 0; c < 6; c++) begin
      check("rstrun_flags", {bus64.in_ready, bus16.in_ready, bus64.out_valid, bus16.out_valid}, 4'b1100);
      @(posedge clk); #1;
    end
    check("rstrun_costs64", bus64.costs, '0);
    check("rstrun_costs16", bus16.costs, '0);
    check("rstrun_best", {bus64.best_state, bus16.best_state}, '0);
    stage(8'h39, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
